// File: rtl/itch_pkg.sv
// Shared definitions for the ITCH message sequencer: message type codes,
// FSM state encoding, parser selection and the beat-count arithmetic.
package itch_pkg;

  localparam logic [7:0] TYPE_A = 8'h41;
  localparam logic [7:0] TYPE_F = 8'h46;
  localparam logic [7:0] TYPE_E = 8'h45;
  localparam logic [7:0] TYPE_C = 8'h43;
  localparam logic [7:0] TYPE_D = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_WAIT_PARSER,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  // Values double as bit positions in parserBusy/parserStart ({D,C,E,F,A}).
  typedef enum logic [2:0] {
    PARSER_A = 3'd0,
    PARSER_F = 3'd1,
    PARSER_E = 3'd2,
    PARSER_C = 3'd3,
    PARSER_D = 3'd4
  } parser_e;

  typedef struct packed {
    logic    known;
    parser_e parser;
  } type_decode_t;

  function automatic type_decode_t decode_type(input logic [7:0] code);
    type_decode_t d;
    d.known  = 1'b1;
    d.parser = PARSER_A;
    case (code)
      TYPE_A:  d.parser = PARSER_A;
      TYPE_F:  d.parser = PARSER_F;
      TYPE_E:  d.parser = PARSER_E;
      TYPE_C:  d.parser = PARSER_C;
      TYPE_D:  d.parser = PARSER_D;
      default: d.known  = 1'b0;
    endcase
    return d;
  endfunction

  // ceil((len+2)/8) in 17 bits so len=16'hFFFF cannot wrap; len 0 still spans one beat.
  function automatic logic [16:0] beat_count(input logic [15:0] len);
    logic [16:0] beats;
    beats = ({1'b0, len} + 17'd9) >> 3;
    if (len == 16'd0) beats = 17'd1;
    return beats;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/itch_beat_counter.sv
// Tracks the beat index within the current message and flags the final beat.
module itch_beat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [16:0] total_in,
  output logic        last
);

  logic [16:0] total;
  logic [16:0] index;

  // Load together with enable means the header beat has already been consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      total <= '0;
      index <= '0;
    end else if (load) begin
      total <= total_in;
      index <= enable ? 17'd1 : 17'd0;
    end else if (enable) begin
      index <= index + 17'd1;
    end
  end

  assign last = (index == total - 17'd1);

endmodule

// File: rtl/itch_message_sequencer.sv
// Routes ITCH messages from a 64-bit beat stream to one of five type-specific
// parsers, discarding unknown or zero-length messages and counting the drops.
module itch_message_sequencer
  import itch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dataIn,
  input  logic        dataValid,
  output logic        dataReady,
  input  logic [4:0]  parserBusy,
  output logic [4:0]  parserStart,
  output logic [63:0] beatData,
  output logic        beatValid,
  output logic        beatLast,
  output logic [15:0] messageLength,
  output logic [15:0] dropCount
);

  state_e       state;
  parser_e      sel_parser;
  logic [63:0]  header_beat;
  logic         header_fwd;
  logic         xfer;
  logic         drop_header;
  logic         cnt_load;
  logic         cnt_enable;
  logic         cnt_last;
  type_decode_t hdr_decode;
  logic [16:0]  hdr_count;
  logic [4:0]   start_onehot;

  assign xfer         = dataValid && dataReady;
  assign hdr_decode   = decode_type(dataIn[23:16]);
  assign hdr_count    = beat_count(dataIn[15:0]);
  assign drop_header  = !hdr_decode.known || (dataIn[15:0] == 16'd0);
  assign start_onehot = 5'b00001 << sel_parser;

  assign cnt_load   = (state == ST_HEADER) && xfer;
  assign cnt_enable = (cnt_load && drop_header)
                    || ((state == ST_STREAM) && (header_fwd || xfer))
                    || ((state == ST_DRAIN) && xfer);

  itch_beat_counter u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .enable   (cnt_enable),
    .total_in (hdr_count),
    .last     (cnt_last)
  );

  // dataReady is registered alongside the state so it always matches the state it serves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dataReady     <= 1'b0;
      parserStart   <= '0;
      beatValid     <= 1'b0;
      beatLast      <= 1'b0;
      beatData      <= '0;
      messageLength <= '0;
      dropCount     <= '0;
      header_beat   <= '0;
      sel_parser    <= PARSER_A;
      header_fwd    <= 1'b0;
    end else begin
      parserStart <= '0;
      beatValid   <= 1'b0;
      beatLast    <= 1'b0;
      case (state)
        ST_IDLE: begin
          state     <= ST_HEADER;
          dataReady <= 1'b1;
        end
        ST_HEADER: begin
          if (xfer) begin
            header_beat   <= dataIn;
            messageLength <= dataIn[15:0];
            sel_parser    <= hdr_decode.parser;
            if (!drop_header) begin
              state     <= ST_WAIT_PARSER;
              dataReady <= 1'b0;
            end else if (hdr_count == 17'd1) begin
              dropCount <= sat_inc(dropCount);
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_WAIT_PARSER: begin
          if (!parserBusy[sel_parser]) begin
            parserStart <= start_onehot;
            header_fwd  <= 1'b1;
            state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // The held header goes out first while input is paused for one cycle.
          if (header_fwd) begin
            header_fwd <= 1'b0;
            beatValid  <= 1'b1;
            beatData   <= header_beat;
            beatLast   <= cnt_last;
            dataReady  <= 1'b1;
            if (cnt_last) state <= ST_HEADER;
          end else if (xfer) begin
            beatValid <= 1'b1;
            beatData  <= dataIn;
            beatLast  <= cnt_last;
            if (cnt_last) state <= ST_HEADER;
          end
        end
        ST_DRAIN: begin
          if (xfer && cnt_last) begin
            dropCount <= sat_inc(dropCount);
            state     <= ST_HEADER;
          end
        end
        default: begin
          state     <= ST_IDLE;
          dataReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itch_message_sequencer.sv
// Self-checking bench: directed vector table, a reset-abandon sequence and
// randomized messages scored against a message-level reference model.
module tb_itch_message_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dataIn;
  logic        dataValid;
  logic        dataReady;
  logic [4:0]  parserBusy;
  logic [4:0]  parserStart;
  logic [63:0] beatData;
  logic        beatValid;
  logic        beatLast;
  logic [15:0] messageLength;
  logic [15:0] dropCount;

  itch_message_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .dataIn        (dataIn),
    .dataValid     (dataValid),
    .dataReady     (dataReady),
    .parserBusy    (parserBusy),
    .parserStart   (parserStart),
    .beatData      (beatData),
    .beatValid     (beatValid),
    .beatLast      (beatLast),
    .messageLength (messageLength),
    .dropCount     (dropCount)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hdrCyc = 0;
  int modelDrops = 0;

  logic [63:0] expData[$];
  bit          expLast[$];
  logic [4:0]  expStart[$];

  int         beatsSeen = 0;
  int         lastSeenAt = 0;
  int         startsSeen = 0;
  int         startCyc = 0;
  logic [4:0] startSeen = '0;

  typedef struct {
    logic [7:0]  typ;
    logic [15:0] len;
    int          busy;
    bit          toggle;
    int          expBeats;
    logic [4:0]  expStart;
    int          expDelay;
    int          expDrop;
  } vec_t;

  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [4:0] parserBitOf(input logic [7:0] typ);
    case (typ)
      8'h41:   return 5'b00001;
      8'h46:   return 5'b00010;
      8'h45:   return 5'b00100;
      8'h43:   return 5'b01000;
      8'h44:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic int modelBeats(input logic [15:0] len);
    return (len == 16'd0) ? 1 : (int'(len) + 2 + 7) / 8;
  endfunction

  function automatic bit isKnown(input logic [7:0] typ, input logic [15:0] len);
    return (len != 16'd0) && (parserBitOf(typ) != 5'b00000);
  endfunction

  // Output monitor: every beat and start pulse is scored against the model queues.
  always @(negedge clk) begin
    if (beatValid) begin
      beatsSeen++;
      if (beatLast) lastSeenAt = beatsSeen;
      if (expData.size() == 0) begin
        checkOutput("unexpected beatValid", 64'(beatValid), 64'd0);
      end else begin
        checkOutput("beatData", beatData, expData.pop_front());
        checkOutput("beatLast", 64'(beatLast), 64'(expLast.pop_front()));
      end
    end
    if (parserStart != 5'd0) begin
      startsSeen++;
      startSeen = parserStart;
      startCyc  = cyc;
      checkOutput("parserStart onehot", 64'($countones(parserStart)), 64'd1);
      if (expStart.size() == 0)
        checkOutput("unexpected parserStart", 64'(parserStart), 64'd0);
      else
        checkOutput("parserStart", 64'(parserStart), 64'(expStart.pop_front()));
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " dataReady"}, 64'(dataReady), 64'd0);
    checkOutput({tag, " parserStart"}, 64'(parserStart), 64'd0);
    checkOutput({tag, " beatValid"}, 64'(beatValid), 64'd0);
    checkOutput({tag, " beatLast"}, 64'(beatLast), 64'd0);
    checkOutput({tag, " beatData"}, beatData, 64'd0);
    checkOutput({tag, " messageLength"}, 64'(messageLength), 64'd0);
    checkOutput({tag, " dropCount"}, 64'(dropCount), 64'd0);
  endtask

  // Drives one message; rstAt >= 0 asserts reset instead of sending that beat.
  task automatic applyStimulus(input logic [7:0] typ, input logic [15:0] len, input int busy,
                               input bit toggle, input int gapPct, input int rstAt);
    int          nb;
    bit          known;
    logic [63:0] beats[$];
    logic [63:0] hdr;
    logic [4:0]  pbit;
    int          busyLeft;
    bit          hdrSent;
    bit          phase;
    int          guard;
    bit          sent;

    nb    = modelBeats(len);
    known = isKnown(typ, len);
    pbit  = parserBitOf(typ);
    hdr   = {$urandom, $urandom};
    hdr[23:0] = {typ, len};
    beats.push_back(hdr);
    for (int i = 1; i < nb; i++) beats.push_back({$urandom, $urandom});

    if (known) begin
      for (int i = 0; i < nb; i++) begin
        expData.push_back(beats[i]);
        expLast.push_back(i == nb - 1);
      end
      expStart.push_back(pbit);
    end else begin
      modelDrops = (modelDrops >= 65535) ? 65535 : modelDrops + 1;
    end

    beatsSeen = 0; lastSeenAt = 0; startsSeen = 0; startSeen = '0; startCyc = 0;
    parserBusy = 5'($urandom) & ~pbit;
    if (busy > 0) parserBusy = parserBusy | pbit;
    busyLeft = busy; hdrSent = 0; phase = 0;

    for (int i = 0; i < nb; i++) begin
      sent = 0; guard = 0;
      while (!sent) begin
        @(negedge clk);
        if (hdrSent && busy > 0) begin
          if (busyLeft > 0) begin
            checkOutput("dataReady while parser busy", 64'(dataReady), 64'd0);
            busyLeft--;
          end else begin
            parserBusy = parserBusy & ~pbit;
          end
        end
        if (startsSeen > 0) parserBusy = 5'($urandom);
        if (i == rstAt) begin
          rst = 1'b1;
          dataValid = 1'b0;
          @(negedge clk);
          checkResetState("mid-message reset");
          expData.delete(); expLast.delete(); expStart.delete();
          modelDrops = 0;
          rst = 1'b0;
          return;
        end
        if (toggle) phase = !phase;
        if ((toggle && phase) || (!toggle && $urandom_range(99) < gapPct)) begin
          dataValid = 1'b0;
        end else begin
          dataValid = 1'b1;
          dataIn    = beats[i];
          if (dataReady) begin
            sent = 1;
            if (i == 0) begin
              hdrSent = 1;
              hdrCyc  = cyc + 1;
            end
          end
        end
        guard++;
        if (!sent && guard > 300) begin
          checkOutput("dataReady timeout", 64'(dataReady), 64'd1);
          dataValid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    dataValid = 1'b0;
  endtask

  task automatic waitDone();
    int guard = 0;
    repeat (2) @(negedge clk);
    while ((expData.size() != 0 || expStart.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (expData.size() != 0 || expStart.size() != 0) begin
      checkOutput("pending expected outputs", 64'(expData.size() + expStart.size()), 64'd0);
      expData.delete(); expLast.delete(); expStart.delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dropBefore;
    rst = 1'b1; dataIn = '0; dataValid = 1'b0; parserBusy = '0;

    //            type   length   busy tog beats start     delay drop
    vecs[0] = '{8'h41, 16'h0024, 0,  1'b0, 5, 5'b00001, 1,  0};
    vecs[1] = '{8'h46, 16'h0010, 10, 1'b0, 3, 5'b00010, 11, 0};
    vecs[2] = '{8'h5A, 16'h0016, 0,  1'b0, 0, 5'b00000, 0,  1};
    vecs[3] = '{8'h44, 16'h001E, 0,  1'b1, 4, 5'b10000, 1,  0};
    vecs[4] = '{8'h41, 16'h0000, 0,  1'b0, 0, 5'b00000, 0,  1};
    vecs[5] = '{8'h41, 16'h0006, 0,  1'b0, 1, 5'b00001, 1,  0};
    vecs[6] = '{8'h43, 16'h0007, 0,  1'b0, 2, 5'b01000, 1,  0};
    vecs[7] = '{8'h45, 16'h0024, 0,  1'b0, 5, 5'b00100, 1,  0};

    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      dropBefore = int'(dropCount);
      applyStimulus(vecs[v].typ, vecs[v].len, vecs[v].busy, vecs[v].toggle, 0, -1);
      waitDone();
      checkOutput($sformatf("vec%0d beat count", v), 64'(beatsSeen), 64'(vecs[v].expBeats));
      checkOutput($sformatf("vec%0d last position", v), 64'(lastSeenAt), 64'(vecs[v].expBeats));
      checkOutput($sformatf("vec%0d start value", v), 64'(startSeen), 64'(vecs[v].expStart));
      checkOutput($sformatf("vec%0d start pulses", v), 64'(startsSeen), 64'(vecs[v].expStart != 0));
      if (vecs[v].expStart != 5'd0)
        checkOutput($sformatf("vec%0d start delay", v), 64'(startCyc - hdrCyc), 64'(vecs[v].expDelay));
      checkOutput($sformatf("vec%0d drop delta", v), 64'(int'(dropCount) - dropBefore), 64'(vecs[v].expDrop));
      checkOutput($sformatf("vec%0d messageLength", v), 64'(messageLength), 64'(vecs[v].len));
    end

    // Reset while beat 2 of a 5-beat E message is pending, then a clean message.
    applyStimulus(8'h45, 16'h0024, 0, 1'b0, 0, 2);
    checkOutput("reset abandon beats", 64'(beatsSeen), 64'd2);
    checkOutput("reset abandon no last", 64'(lastSeenAt), 64'd0);
    applyStimulus(8'h43, 16'h0024, 0, 1'b0, 0, -1);
    waitDone();
    checkOutput("post-reset beats", 64'(beatsSeen), 64'd5);
    checkOutput("post-reset last", 64'(lastSeenAt), 64'd5);
    checkOutput("post-reset start", 64'(startSeen), 64'b01000);
    checkOutput("post-reset dropCount", 64'(dropCount), 64'd0);

    for (int m = 0; m < 40; m++) begin
      logic [7:0]  t;
      logic [15:0] l;
      int          b;
      bit          kn;
      case ($urandom_range(6))
        0: t = 8'h41;
        1: t = 8'h46;
        2: t = 8'h45;
        3: t = 8'h43;
        4: t = 8'h44;
        5: t = 8'($urandom);
        default: t = 8'h5A;
      endcase
      l  = ($urandom_range(9) == 0) ? 16'd0 : 16'($urandom_range(70));
      kn = isKnown(t, l);
      b  = (kn && modelBeats(l) > 1) ? int'($urandom_range(4)) : 0;
      applyStimulus(t, l, b, 1'b0, 30, -1);
      waitDone();
      checkOutput($sformatf("rand%0d beat count", m), 64'(beatsSeen), 64'(kn ? modelBeats(l) : 0));
      checkOutput($sformatf("rand%0d start pulses", m), 64'(startsSeen), 64'(kn));
      checkOutput($sformatf("rand%0d dropCount", m), 64'(dropCount), 64'(modelDrops));
      checkOutput($sformatf("rand%0d messageLength", m), 64'(messageLength), 64'(l));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
